// File: rtl/det_frame_ctrl.sv
// Frame controller for a serial 1010 Mealy detector: clears it, shifts a WIDTH-bit word MSB first, counts hits.
// Response is held until rsp_ready; requests are only accepted in IDLE, so rsp stall backpressures req.
module det_frame_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_ovl,
  output logic             det_rst,
  output logic             det_in,
  output logic             det_wl,
  input  logic             det_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] rsp_count,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_first
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLR   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic             armed;
  logic [WIDTH-1:0] shreg;
  logic             ovl_q;
  logic [IDX_W-1:0] idx;
  logic             accept;

  // armed keeps req_ready low while rst is asserted and for the release cycle
  assign req_ready = armed && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign det_rst   = (state != SHIFT);
  assign det_in    = (state == SHIFT) && shreg[WIDTH-1];
  assign det_wl    = (state == SHIFT) && ovl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      shreg     <= '0;
      ovl_q     <= 1'b0;
      idx       <= '0;
      rsp_count <= '0;
      rsp_hit   <= 1'b0;
      rsp_first <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg     <= req_data;
            ovl_q     <= req_ovl;
            idx       <= '0;
            rsp_count <= '0;
            rsp_hit   <= 1'b0;
            rsp_first <= '0;
            state     <= CLR;
          end
        end
        CLR: begin
          state <= SHIFT;
        end
        SHIFT: begin
          if (det_out) begin
            if (rsp_count != CNT_MAX) begin
              rsp_count <= rsp_count + CNT_W'(1);
            end
            if (!rsp_hit) begin
              rsp_hit   <= 1'b1;
              rsp_first <= idx;
            end
          end
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          idx   <= idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            state <= RESP;
          end
        end
        default: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_det_frame_ctrl.sv
// Directed bench for det_frame_ctrl driving a behavioural 1010 Mealy detector; a CNT_W=1 twin checks saturation.
module tb_det_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ovl, rsp_ready;
  logic [7:0] req_data;
  logic       req_ready, det_rst, det_in, det_wl, det_out, rsp_valid, rsp_hit;
  logic [3:0] rsp_count;
  logic [2:0] rsp_first;

  logic       req_ready_s, det_rst_s, det_in_s, det_wl_s, rsp_valid_s, rsp_hit_s;
  logic [0:0] rsp_count_s;
  logic [2:0] rsp_first_s;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  det_frame_ctrl #(.WIDTH(8), .CNT_W(4), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_ovl(req_ovl), .det_rst(det_rst), .det_in(det_in),
    .det_wl(det_wl), .det_out(det_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_count(rsp_count), .rsp_hit(rsp_hit), .rsp_first(rsp_first)
  );

  // Twin sees identical inputs, so the shared detector output is valid for it too
  det_frame_ctrl #(.WIDTH(8), .CNT_W(1), .IDX_W(3)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_data(req_data), .req_ovl(req_ovl), .det_rst(det_rst_s), .det_in(det_in_s),
    .det_wl(det_wl_s), .det_out(det_out), .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
    .rsp_count(rsp_count_s), .rsp_hit(rsp_hit_s), .rsp_first(rsp_first_s)
  );

  // 1010 Mealy detector: 0=none, 1="1", 2="10", 3="101"
  logic [1:0] dst;
  assign det_out = (dst == 2'd3) && !det_in;
  always @(posedge clk) begin
    if (det_rst) dst <= 2'd0;
    else begin
      case (dst)
        2'd0: dst <= det_in ? 2'd1 : 2'd0;
        2'd1: dst <= det_in ? 2'd1 : 2'd2;
        2'd2: dst <= det_in ? 2'd3 : 2'd0;
        default: dst <= det_in ? 2'd1 : (det_wl ? 2'd2 : 2'd0);
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tg);
    chk({tg, "_req_ready"}, req_ready, 0);
    chk({tg, "_det_rst"}, det_rst, 1);
    chk({tg, "_det_in"}, det_in, 0);
    chk({tg, "_det_wl"}, det_wl, 0);
    chk({tg, "_rsp_valid"}, rsp_valid, 0);
    chk({tg, "_rsp_count"}, rsp_count, 0);
    chk({tg, "_rsp_hit"}, rsp_hit, 0);
    chk({tg, "_rsp_first"}, rsp_first, 0);
  endtask

  // Called at a negedge; runs one frame end to end and checks the response
  task automatic do_frame(input string tg, input logic [7:0] d, input logic ovl,
                          input int ecnt, input int ehit, input int efirst,
                          input int ecnt_s, input int stall);
    int n;
    int edges;
    req_data  = d;
    req_ovl   = ovl;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tg, "_acc"}, req_ready, 1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    // Scramble inputs after accept: the frame in flight must not notice
    req_valid = 1'b0;
    req_data  = ~d;
    req_ovl   = ~ovl;
    chk({tg, "_clr_det_rst"}, det_rst, 1);
    while (!rsp_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 2) begin
        chk({tg, "_shift_det_rst"}, det_rst, 0);
        chk({tg, "_shift_det_wl"}, det_wl, ovl);
      end
    end
    chk({tg, "_latency"}, edges, 10);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      chk({tg, "_stall_count"}, rsp_count, ecnt);
      chk({tg, "_stall_first"}, rsp_first, efirst);
      chk({tg, "_stall_req_ready"}, req_ready, 0);
      @(negedge clk);
      chk({tg, "_stall_valid"}, rsp_valid, 1);
    end
    req_valid = 1'b0;
    chk({tg, "_count"}, rsp_count, ecnt);
    chk({tg, "_hit"}, rsp_hit, ehit);
    chk({tg, "_first"}, rsp_first, efirst);
    chk({tg, "_sat_count"}, rsp_count_s, ecnt_s);
    chk({tg, "_sat_first"}, rsp_first_s, efirst);
    chk({tg, "_resp_det_rst"}, det_rst, 1);
    chk({tg, "_resp_det_in"}, det_in, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tg, "_post_valid"}, rsp_valid, 0);
    chk({tg, "_post_req_ready"}, req_ready, 1);
    chk({tg, "_post_det_rst"}, det_rst, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_ovl   = 1'b0;
    req_data  = 8'h00;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("release_req_ready", req_ready, 1);

    do_frame("ovl_aa",  8'b1010_1010, 1'b1, 3, 1, 3, 1, 0);
    do_frame("novl_aa", 8'b1010_1010, 1'b0, 2, 1, 3, 1, 0);
    do_frame("zeros",   8'h00,        1'b1, 0, 0, 0, 0, 0);
    do_frame("ones",    8'hFF,        1'b0, 0, 0, 0, 0, 0);
    do_frame("tail05",  8'b0000_0101, 1'b1, 0, 0, 0, 0, 0);
    do_frame("head40",  8'b0100_0000, 1'b1, 0, 0, 0, 0, 0);
    do_frame("stall",   8'b1010_1010, 1'b0, 2, 1, 3, 1, 5);

    // Reset in the 4th SHIFT cycle discards the frame
    req_data  = 8'b1010_1010;
    req_ovl   = 1'b1;
    req_valid = 1'b1;
    chk("mid_acc", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_in_shift", det_rst, 0);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_rsp", rsp_valid, 0);
    chk("midrst_idle_det_rst", det_rst, 1);
    do_frame("after_rst", 8'b1010_1010, 1'b1, 3, 1, 3, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
